// File: rtl/bit_permute_pkg.sv
// Shared types and the width-generic permutation function for bit_permute_reg.
// The buffer occupancy enum doubles as the skid buffer state encoding.
package bit_permute_pkg;

  typedef enum logic [1:0] {
    PASS            = 2'd0,
    BIT_REV         = 2'd1,
    BYTE_SWAP       = 2'd2,
    BIT_REV_IN_BYTE = 2'd3
  } perm_mode_e;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  localparam int PERM_MAX_W = 256;
  localparam int PERM_IDX_W = $clog2(PERM_MAX_W);

  // Operates on the low w bits of a PERM_MAX_W carrier; w must be a
  // multiple of 8 and a constant at each call site.
  function automatic logic [PERM_MAX_W-1:0] permute_word(
    input logic [PERM_MAX_W-1:0] d,
    input int                    w,
    input perm_mode_e            m
  );
    logic [PERM_MAX_W-1:0] r;
    int                    nb;
    int                    src;
    r  = '0;
    nb = w / 8;
    for (int i = 0; i < PERM_MAX_W; i++) begin
      if (i < w) begin
        case (m)
          BIT_REV:         src = w - 1 - i;
          BYTE_SWAP:       src = (nb - 1 - i / 8) * 8 + i % 8;
          BIT_REV_IN_BYTE: src = (i / 8) * 8 + 7 - i % 8;
          default:         src = i;
        endcase
        r[i[PERM_IDX_W-1:0]] = d[src[PERM_IDX_W-1:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_permute_if.sv
// Stream bundle for bit_permute_reg: input word/mode, permuted output and transfer count.
// Handshakes: a transfer happens in a cycle where valid and ready are both high.
interface bit_permute_if
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  perm_mode_e       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  occ_e             occ;
`ifdef BIT_PERMUTE_PARITY_EN
  logic             out_parity;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count, occ, out_parity
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_count, occ, out_parity
  );
`else
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count, occ
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_count, occ
  );
`endif
endinterface

// File: rtl/bit_permute_skid.sv
// Two-entry FIFO-ordered valid/ready buffer; head entry drives the output directly.
// in_ready is registered from next occupancy, so there is no path from out_ready.
module bit_permute_skid
  import bit_permute_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output occ_e          state_o
);

  occ_e          state_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          valid_q;
  logic          ready_q;
  logic          push;
  logic          pop;

  assign push = in_valid_i & ready_q;
  assign pop  = valid_q & out_ready_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= OCC_0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        OCC_0: begin
          if (push) begin
            head_q  <= in_data_i;
            state_q <= OCC_1;
            valid_q <= 1'b1;
          end
        end
        OCC_1: begin
          if (push && pop) begin
            head_q <= in_data_i;
          end else if (push) begin
            tail_q  <= in_data_i;
            state_q <= OCC_2;
            ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= OCC_0;
            valid_q <= 1'b0;
          end
        end
        // Full: ready_q is low here, so no push can coincide with the pop.
        OCC_2: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= OCC_1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= OCC_0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign state_o     = state_q;

endmodule

// File: rtl/bit_permute_reg.sv
// Registered bit/byte permuter with 2-entry output buffer and transfer counter.
// Optional macro BIT_PERMUTE_PARITY_EN adds a per-word even-parity output.
module bit_permute_reg
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
)(
  input  logic  clk,
  input  logic  reset,
  bit_permute_if.slave bus
);

`ifdef BIT_PERMUTE_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [WIDTH-1:0] perm;
  logic [DW-1:0]    skid_in;
  logic [DW-1:0]    skid_out;
  logic             in_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_count_q;
  logic [CNT_W-1:0] out_count_d;

  always_comb begin
    perm = WIDTH'(permute_word(PERM_MAX_W'(bus.in_data), WIDTH, bus.in_mode));
  end

`ifdef BIT_PERMUTE_PARITY_EN
  assign skid_in = {^perm, perm};
`else
  assign skid_in = perm;
`endif

  bit_permute_skid #(
    .DW (DW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (skid_in),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (skid_out),
    .state_o     (bus.occ)
  );

  always_comb begin
    out_count_d = out_count_q;
    if (out_valid && bus.out_ready) begin
      out_count_d = out_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_count_q <= '0;
    end else begin
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = skid_out[WIDTH-1:0];
  assign bus.out_count = out_count_q;
`ifdef BIT_PERMUTE_PARITY_EN
  assign bus.out_parity = skid_out[WIDTH];
`endif

endmodule

// File: tb/tb_bit_permute_reg.sv
// Bench for bit_permute_reg (WIDTH=16, CNT_W=4): vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bit_permute_reg;
  import bit_permute_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;

  bit_permute_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  bit_permute_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           exp_cnt;
  bit           exp_rdy;
  int           n_checks;
  int           n_pass;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         par;
  } vec_t;
  vec_t vecs[4];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // reference permutation built from streaming operators
  function automatic logic [W-1:0] ref_perm(logic [W-1:0] d, logic [1:0] m);
    logic [W-1:0] rev;
    logic [W-1:0] swp;
    logic [W-1:0] r;
    rev = {<<{d}};
    swp = {<<8{d}};
    case (m)
      2'd0:    r = d;
      2'd1:    r = rev;
      2'd2:    r = swp;
      default: r = {<<8{rev}};
    endcase
    return r;
  endfunction

  // one clock: update model from handshakes seen now, advance, compare
  task automatic step();
    bit           push;
    bit           pop;
    logic [W-1:0] e;
    push = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    pop  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    if (reset !== 1'b1) begin
      exp_q.delete();
      exp_cnt = 0;
      exp_rdy = 1'b0;
    end else begin
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("spurious_pop", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", 32'(bus.out_data), 32'(e));
          got_q.push_back(bus.out_data);
        end
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      if (push) exp_q.push_back(ref_perm(bus.in_data, bus.in_mode));
      exp_rdy = (exp_q.size() < 2);
    end
    @(posedge clk);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("out_count", 32'(bus.out_count), 32'(exp_cnt));
    check("occupancy", 32'(bus.occ), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check("head_data", 32'(bus.out_data), 32'(exp_q[0]));
`ifdef BIT_PERMUTE_PARITY_EN
      check("head_parity", 32'(bus.out_parity), 32'(^exp_q[0]));
`endif
    end
  endtask

  // driver: offer one word until accepted (bounded)
  task automatic send(input logic [W-1:0] d, input logic [1:0] m);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = perm_mode_e'(m);
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = (bus.in_ready === 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("drain_empty", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    bit acc;
    int nacc;
    int ncyc;
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;
    exp_rdy  = 1'b0;
    vecs[0] = '{mode: 2'd1, din: 16'h00B1, dout: 16'h8D00, par: 1'b0};
    vecs[1] = '{mode: 2'd2, din: 16'h1234, dout: 16'h3412, par: 1'b1};
    vecs[2] = '{mode: 2'd3, din: 16'h0180, dout: 16'h8001, par: 1'b0};
    vecs[3] = '{mode: 2'd0, din: 16'hBEEF, dout: 16'hBEEF, par: 1'b1};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = PASS;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    step();
    check("ready_after_release", 32'(bus.in_ready), 32'd1);

    // table vectors: result visible one cycle after acceptance
    foreach (vecs[i]) begin
      bus.out_ready = 1'b0;
      send(vecs[i].din, vecs[i].mode);
      check("vec_valid", 32'(bus.out_valid), 32'd1);
      check("vec_data", 32'(bus.out_data), 32'(vecs[i].dout));
`ifdef BIT_PERMUTE_PARITY_EN
      check("vec_parity", 32'(bus.out_parity), 32'(vecs[i].par));
`endif
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end

    // backpressure: A, B accepted, C blocked until space frees
    do_reset();
    got_q.delete();
    bus.out_ready = 1'b0;
    send(16'h0001, 2'd0);
    check("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
    send(16'h0002, 2'd0);
    check("bp_ready_after_b", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0003;
    bus.in_mode  = PASS;
    step();
    check("bp_c_blocked", 32'(bus.occ), 32'd2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && bus.in_valid; k++) begin
      acc = (bus.in_ready === 1'b1);
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    check("bp_c_accepted", 32'(bus.in_valid), 32'd0);
    drain();
    check("bp_pops", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("bp_first", 32'(got_q[0]), 32'h0001);
      check("bp_second", 32'(got_q[1]), 32'h0002);
      check("bp_third", 32'(got_q[2]), 32'h0003);
    end
    check("bp_count", 32'(bus.out_count), 32'd3);

    // reset with two words buffered and handshakes offered
    bus.out_ready = 1'b0;
    send(16'hAAAA, 2'd1);
    send(16'h5555, 2'd2);
    check("mid_occ", 32'(bus.occ), 32'd2);
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus.out_count), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check("mid_rel_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rel_valid", 32'(bus.out_valid), 32'd0);

    // 17 streamed transfers: one per cycle, 4-bit counter wraps to 1
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = BIT_REV;
    nacc = 0;
    ncyc = 0;
    for (int k = 0; k < 40 && nacc < 17; k++) begin
      bus.in_data = 16'(k * 16'h1111 + 3);
      if (bus.in_ready === 1'b1) nacc++;
      ncyc++;
      step();
    end
    bus.in_valid = 1'b0;
    check("wrap_cycles", 32'(ncyc), 32'd17);
    drain();
    check("wrap_count", 32'(bus.out_count), 32'd1);

    // randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      reset         = ($urandom_range(0, 79) != 0);
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_data   = 16'($urandom);
      bus.in_mode   = perm_mode_e'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_permute_reg.md
BIT_PERMUTE_REG -- requirements
Module: bit_permute_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter CNT_W, default 16, transfer-counter width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  WIDTH  input word.
REQ-008 SHALL have port in_mode  input  2  permutation selected for this word.
REQ-009 SHALL have port out_valid  output  1  output word available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output word.
REQ-011 SHALL have port out_data  output  WIDTH  permuted word.
REQ-012 SHALL have port out_count  output  CNT_W  number of completed output transfers.

Function
REQ-013 SHALL define in_mode encodings:
- 0 PASS: out = in.
- 1 BIT_REV: out[i] = in[WIDTH-1-i].
- 2 BYTE_SWAP: reverses byte order; bits within each byte are unchanged.
- 3 BIT_REV_IN_BYTE: reverses bits within each byte; byte order is unchanged.
REQ-014 SHALL accept a word only on an input handshake (in_valid and in_ready high in the same cycle), using the in_mode sampled in that cycle.
REQ-015 SHALL register the permuted word; the result is presented on out_valid/out_data the cycle after acceptance when the buffer was empty (latency 1).
REQ-016 SHALL buffer up to 2 words in a FIFO-ordered skid store; occupancy is 0, 1 or 2.
REQ-017 SHALL drive in_ready high exactly when occupancy is below 2; in_ready is a registered signal with no combinational path from out_ready.
REQ-018 SHALL complete an output transfer when out_valid and out_ready are both high; the head entry is then removed.
REQ-019 SHALL, on a simultaneous input and output handshake, leave occupancy unchanged and preserve word order.
REQ-020 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-021 SHALL ignore in_data and in_mode whenever no input handshake occurs.
REQ-022 SHALL increment out_count by 1 on every output handshake, wrapping from all-ones to 0.
REQ-023 SHALL sustain one word per cycle when out_ready is held high.

Reset
REQ-024 SHALL, while reset is low at a rising clk edge, set occupancy = 0, out_valid = 0, out_data = 0, out_count = 0 and in_ready = 0.
REQ-025 SHALL drive in_ready = 1 on the first edge after reset returns high.
REQ-026 SHALL discard buffered words and drop any in-flight handshake when reset is asserted mid-operation; no output handshake completes in that cycle.

Configuration
REQ-027 SHALL support macro BIT_PERMUTE_PARITY_EN:
- When defined: adds output out_parity (1 bit), the even parity (XOR reduction) of out_data; it is stored per buffer entry, follows its word, and resets to 0.
- When undefined: the port and its storage are absent, and all other behaviour is identical.

Structure
REQ-028 SHALL place the mode enum type (PASS, BIT_REV, BYTE_SWAP, BIT_REV_IN_BYTE) in shared package bit_permute_pkg.
REQ-029 SHALL implement the permutation as a combinational function in bit_permute_pkg, parametrised on width.
REQ-030 SHALL instantiate exactly one sub-module, bit_permute_skid, the 2-entry valid/ready buffer; its data width covers the data plus the optional parity bit.

Verification
REQ-031 SHALL cover, with WIDTH=16, each scenario below:
- BIT_REV, 0x00B1 -> 0x8D00 one cycle later; out_parity = 0 when enabled.
- BYTE_SWAP, 0x1234 -> 0x3412.
- BIT_REV_IN_BYTE, 0x0180 -> 0x8001.
- PASS, 0xBEEF -> 0xBEEF.
- Backpressure: out_ready = 0, offer A = 0x0001, B = 0x0002, C = 0x0003 in PASS:
  - A and B are accepted; in_ready drops the cycle after B.
  - Raising out_ready yields A, then B, then C.
  - out_count reads 3 afterwards.
- Reset mid-stream with occupancy 2: out_valid = 0, out_count = 0 on the next edge; in_ready returns the edge after release.
- Counter wrap: CNT_W = 4; 17 transfers -> out_count = 1.
